// File: rtl/slow_div.sv
`default_nettype none
// ============================================================================
// Module   : slow_div
// Brief    : Sequential restoring divider. It divides a 2*DW-bit dividend by
//            a DW-bit divisor and produces one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module slow_div #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            valid,
    output logic [2*DW-1:0] quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero
);

    localparam int             CW     = $clog2(2 * DW);
    localparam logic [0:0]     c_IDLE = 1'b0;
    localparam logic [0:0]     c_RUN  = 1'b1;
    localparam logic [CW-1:0]  c_LAST = CW'(2 * DW - 1);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_div;
    logic [2*DW-1:0] r_shift;
    logic [DW:0]     r_rem;
    logic            r_valid;
    logic [2*DW-1:0] r_quot;
    logic [DW-1:0]   r_remout;
    logic            r_dz;

    logic            w_req;
    logic            w_launch;
    logic            w_zero_req;
    logic            w_last;
    logic [DW+1:0]   w_rem_sh;
    logic [DW+1:0]   w_trial;
    logic            w_qbit;
    logic [DW:0]     w_rem_nxt;
    logic [2*DW-1:0] w_shift_nxt;

    assign w_req      = (r_state == c_IDLE) && start;
    assign w_launch   = w_req && (divisor != '0);
    assign w_zero_req = w_req && (divisor == '0);
    assign w_last     = (r_state == c_RUN) && (r_cnt == c_LAST);

    // The shifted partial remainder is always below 2*divisor, so its top bit
    // is zero and w_trial[DW+1] acts as the borrow bit of the trial subtraction.
    assign w_rem_sh    = {r_rem, r_shift[2*DW-1]};
    assign w_trial     = w_rem_sh - {2'b00, r_div};
    assign w_qbit      = ~w_trial[DW+1];
    assign w_rem_nxt   = w_qbit ? w_trial[DW:0] : w_rem_sh[DW:0];
    assign w_shift_nxt = {r_shift[2*DW-2:0], w_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_launch) w_state_nxt = c_RUN;
            c_RUN:   if (w_last)   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_div    <= '0;
            r_shift  <= '0;
            r_rem    <= '0;
            r_valid  <= 1'b0;
            r_quot   <= '0;
            r_remout <= '0;
            r_dz     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_launch) begin
                r_div   <= divisor;
                r_shift <= dividend;
                r_rem   <= '0;
                r_cnt   <= '0;
            end else if (w_zero_req) begin
                r_valid  <= 1'b1;
                r_dz     <= 1'b1;
                r_quot   <= '1;
                r_remout <= '0;
            end else if (r_state == c_RUN) begin
                r_shift <= w_shift_nxt;
                r_rem   <= w_rem_nxt;
                r_cnt   <= r_cnt + 1'b1;
                if (w_last) begin
                    r_valid  <= 1'b1;
                    r_dz     <= 1'b0;
                    r_quot   <= w_shift_nxt;
                    r_remout <= w_rem_nxt[DW-1:0];
                end
            end
        end
    end

    assign valid       = r_valid;
    assign quotient    = r_quot;
    assign remainder   = r_remout;
    assign div_by_zero = r_dz;

endmodule
`default_nettype wire

// File: doc/slow_div.md
# slow_div

Sequential restoring divider: unsigned 2·DW-bit dividend by DW-bit divisor, one quotient bit per clock. It is the inverse companion of the slow shift-add multiplier in the DSP arithmetic library. It uses the same start/busy/valid handshake, so a multiplier product divided by its multiplicand returns the multiplier. It is intended for low-area datapaths where 2·DW-cycle latency is acceptable.

## Interface
- DW, 8, operand width; dividend and quotient are 2·DW bits, divisor and remainder are DW bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on a rising edge only when busy=0.
- dividend  input  2·DW  unsigned numerator; sampled with start.
- divisor  input  DW  unsigned denominator; sampled with start.
- busy  output  1  high while an iteration sequence is in progress.
- valid  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid in that cycle.
- quotient  output  2·DW  floor(dividend/divisor).
- remainder  output  DW  dividend mod divisor.
- div_by_zero  output  1  set with valid when the sampled divisor was 0.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1, iteration counter 0..2·DW-1.
- IDLE → RUN on an edge with start=1 and divisor≠0:
  - Latch the divisor.
  - Load the shift register with the dividend.
  - Clear the (DW+1)-bit partial remainder.
  - Clear the counter.
- RUN, each edge:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor from the partial remainder (DW+1 bits).
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Increment the counter.
- RUN → IDLE on the edge that completes iteration 2·DW-1. On that same edge:
  - quotient and remainder registers load the final results.
  - valid is set to 1 and div_by_zero to 0.
- Divide by zero: an IDLE edge with start=1 and divisor=0 stays in IDLE. On that same edge:
  - valid=1, div_by_zero=1.
  - quotient set to all ones, remainder set to 0.
  - busy never asserts.
- valid clears on the following edge. quotient, remainder and div_by_zero hold their values until the next completion.
- start while busy=1 is ignored: no effect on the operation in progress, not queued.
- start held high continuously launches a new operation on the first edge where busy=0. That is the edge after valid, since valid and busy-fall coincide.
- Arithmetic is unsigned only; remainder < divisor always holds for divisor≠0.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
  - Takes effect immediately, including mid-operation; the partial result is discarded.
- Normal latency:
  - Start sampled at edge E0 → busy=1 after E0.
  - busy=0 and valid=1 after edge E0+2·DW, i.e. 16 cycles for DW=8.
  - Valid is therefore visible during the cycle following edge E0+2·DW.
- Divide-by-zero latency: valid=1 after E0 itself, i.e. 1 cycle.
- Throughput: one operation per 2·DW+1 cycles with start held high.
- Input operands need only be stable at the start-sampling edge.

## Test plan
- Basic division, DW=8: dividend=1000, divisor=7 → quotient=142, remainder=6, div_by_zero=0.
  - busy high for exactly 16 cycles.
  - valid is a single-cycle pulse after the 16th edge.
- Extremes:
  - 65535/1 → q=65535, r=0.
  - 65535/255 → q=257, r=0.
  - 0/200 → q=0, r=0.
  - 254/255 → q=0, r=254.
- Divide by zero: 1234/0 → valid one cycle after start, div_by_zero=1, quotient=16'hFFFF, remainder=0, busy stays 0.
  - A following 100/3 → q=33, r=1, div_by_zero=0.
- Start while busy: launch 5000/9, then pulse start at iteration 5 with 10/2.
  - Exactly one valid, result q=555, r=5.
  - The second request produces nothing.
- Reset mid-operation: assert rst_n=0 at iteration 8 of 40000/13.
  - All outputs read 0 immediately.
  - After release no valid appears; a new 40000/13 gives q=3076, r=12.
- Random round-trip: 200 random pairs (a≠0, b) form dividend=a·b, divisor=a → quotient=b, remainder=0.
  - Plus 200 random (n, d≠0) checked against q·d+r==n and r<d; any mismatch is reported as an error.
